fetch_stage: RTL and testbench

Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of decode and the hazard detection controller. It owns the PC, issues requests to instruction memory over a req/gnt + rvalid interface, and buffers returned instructions in a 2-entry queue. Decode holds the queue head while the hazard controller's stall is high. On a branch/jump redirect, queued and in-flight instructions are flushed.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fetch_insn_fifo.sv | 55 +++++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline front end (fetch stage and its
// instruction queue).
package pipeline_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSN_W      = 32;
  localparam int FETCH_DEPTH = 2;

  localparam logic [INSN_W-1:0] INSN_NOP = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_insn_fifo.sv
// Two-entry synchronous queue of {pc, insn} between instruction memory and decode.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_insn_fifo
  import pipeline_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_push_pc,
  input  logic [INSN_W-1:0] i_push_insn,
  output logic [1:0]        o_count,
  output logic [ADDR_W-1:0] o_head_pc,
  output logic [INSN_W-1:0] o_head_insn
);

  localparam logic [1:0] DEPTH = 2'(FETCH_DEPTH);

  logic [ADDR_W-1:0] r_pc   [FETCH_DEPTH];
  logic [INSN_W-1:0] r_insn [FETCH_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_do_pop  = i_pop & (r_count != 2'd0);
  assign w_do_push = i_push & ((r_count != DEPTH) | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Payload is qualified by r_count, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) begin
      r_pc[r_wr_ptr]   <= i_push_pc;
      r_insn[r_wr_ptr] <= i_push_insn;
    end
  end

  assign o_count     = r_count;
  assign o_head_pc   = r_pc[r_rd_ptr];
  assign o_head_insn = r_insn[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests and queues
// returned words for decode. FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_stall,
  input  logic              w_redirect,
  input  logic [ADDR_W-1:0] w_redirect_pc_32,
  output logic              w_imem_req,
  output logic [ADDR_W-1:0] w_imem_addr_32,
  input  logic              w_imem_gnt,
  input  logic              w_imem_rvalid,
  input  logic [INSN_W-1:0] w_imem_rdata_32,
  output logic              w_insn_valid,
  output logic [INSN_W-1:0] w_insn_32,
  output logic [ADDR_W-1:0] w_insn_pc_32
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       w_stall_cnt_32,
  output logic [31:0]       w_redirect_cnt_32
`endif
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [1:0]        r_outstanding;
  logic [1:0]        w_outstanding_next;
  logic [1:0]        r_drop_cnt;
  logic [1:0]        w_drop_next;
  logic [ADDR_W-1:0] r_trk_pc [FETCH_DEPTH];
  logic              r_trk_wr;
  logic              r_trk_rd;
  logic [1:0]        w_fifo_count;
  logic [ADDR_W-1:0] w_head_pc;
  logic [INSN_W-1:0] w_head_insn;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic [2:0]        w_occupancy;

  assign w_valid     = (w_fifo_count != 2'd0);
  assign w_pop       = w_valid & ~w_stall & ~w_redirect;
  // Every in-flight request must have a queue slot waiting for it.
  assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_fifo_count} - {2'b00, w_pop};
  assign w_imem_req  = (w_occupancy < 3'd2) & ~reset;
  assign w_imem_addr_32 = r_fetch_pc;
  assign w_accept    = w_imem_req & w_imem_gnt;
  assign w_outstanding_next = r_outstanding + {1'b0, w_accept} - {1'b0, w_imem_rvalid};

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop_cnt;
    w_push       = 1'b0;
    if (w_redirect) begin
      w_drop_next  = w_outstanding_next;
      w_state_next = (w_outstanding_next != 2'd0) ? FLUSH : RUN;
    end else begin
      case (r_state)
        RUN: w_push = w_imem_rvalid;
        FLUSH: begin
          if (w_imem_rvalid) begin
            w_drop_next = r_drop_cnt - 2'd1;
            if (r_drop_cnt == 2'd1) w_state_next = RUN;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
      r_trk_wr      <= 1'b0;
      r_trk_rd      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_drop_cnt    <= w_drop_next;
      r_outstanding <= w_outstanding_next;
      if (w_redirect)    r_fetch_pc <= w_redirect_pc_32;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_accept)      r_trk_wr <= ~r_trk_wr;
      if (w_imem_rvalid) r_trk_rd <= ~r_trk_rd;
    end
  end

  // Issued-PC tracker: responses return in order, so PCs pop in grant order.
  always_ff @(posedge clock) begin
    if (w_accept) r_trk_pc[r_trk_wr] <= r_fetch_pc;
  end

  fetch_insn_fifo u_insn_fifo (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_clear     (w_redirect),
    .i_push_pc   (r_trk_pc[r_trk_rd]),
    .i_push_insn (w_imem_rdata_32),
    .o_count     (w_fifo_count),
    .o_head_pc   (w_head_pc),
    .o_head_insn (w_head_insn)
  );

  assign w_insn_valid = w_valid;
  assign w_insn_32    = w_valid ? w_head_insn : INSN_NOP;
  assign w_insn_pc_32 = w_valid ? w_head_pc : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_redirect_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt    <= 32'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      if (w_stall && w_valid) r_stall_cnt    <= sat_inc(r_stall_cnt);
      if (w_redirect)         r_redirect_cnt <= sat_inc(r_redirect_cnt);
    end
  end

  assign w_stall_cnt_32    = r_stall_cnt;
  assign w_redirect_cnt_32 = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order imem model plus a program-order scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, stall, redirect, gnt, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        d_req, d_valid;
  logic [31:0] d_addr, d_insn, d_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] d_stall_cnt, d_redir_cnt;
`endif

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clock            (clock),
    .reset            (reset),
    .w_stall          (stall),
    .w_redirect       (redirect),
    .w_redirect_pc_32 (redirect_pc),
    .w_imem_req       (d_req),
    .w_imem_addr_32   (d_addr),
    .w_imem_gnt       (gnt),
    .w_imem_rvalid    (rvalid),
    .w_imem_rdata_32  (rdata),
    .w_insn_valid     (d_valid),
    .w_insn_32        (d_insn),
    .w_insn_pc_32     (d_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .w_stall_cnt_32    (d_stall_cnt),
    .w_redirect_cnt_32 (d_redir_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // memory model: mode 0 = always grant, 1 = grant after 3 waiting cycles, 2 = random
  int          mode, lat, gnt_wait, last_due;
  logic [31:0] pq_addr[$];
  int          pq_due[$];

  logic        s_reset, s_stall, s_redirect, s_req, s_gnt, s_valid;
  logic [31:0] s_rpc, s_addr, s_insn, s_pc;
  logic        p_reset = 1'b1, p_stall = 1'b0, p_redirect = 1'b0, p_req = 1'b0, p_gnt = 1'b0, p_valid = 1'b0;
  logic [31:0] p_rpc = '0, p_addr = '0, p_insn = '0, p_pc = '0;
  logic        q_reset = 1'b1, q_redirect = 1'b0;

  logic [31:0] exp_pc, last_pop_pc, exp_stall, exp_redir;
  int          pops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int l, due;
    logic g;
    #8;
    s_reset = reset; s_stall = stall; s_redirect = redirect; s_rpc = redirect_pc;
    s_req = d_req; s_gnt = gnt; s_addr = d_addr; s_valid = d_valid; s_insn = d_insn; s_pc = d_pc;
    if (!s_reset && !p_reset) begin
      if (p_redirect) begin
        chk("redir_next_valid", 32'(s_valid), 32'd0);
        chk("redir_next_addr", s_addr, p_rpc);
      end
      if (q_redirect && !q_reset) chk("redir_second_valid", 32'(s_valid), 32'd0);
      if (p_req && !p_gnt && !p_redirect) begin
        chk("req_hold", 32'(s_req), 32'd1);
        chk("addr_hold", s_addr, p_addr);
      end
      if (p_valid && p_stall && !p_redirect) begin
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_pc", s_pc, p_pc);
        chk("stall_insn", s_insn, p_insn);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (s_reset) begin
      exp_pc = RESET_PC; exp_stall = '0; exp_redir = '0;
      pq_addr.delete(); pq_due.delete(); last_due = 0;
    end else begin
      if (s_valid && !s_stall && !s_redirect) begin
        chk("pop_pc", s_pc, exp_pc);
        chk("pop_insn", s_insn, exp_pc + 32'd1);
        last_pop_pc = s_pc;
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (s_redirect) begin
        exp_pc = s_rpc;
        if (exp_redir != 32'hFFFF_FFFF) exp_redir++;
      end
      if (s_stall && s_valid && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      if (s_req && s_gnt) begin
        l = (mode == 2) ? int'($urandom_range(1, 3)) : lat;
        due = cyc - 1 + l;
        if (due < last_due) due = last_due;
        last_due = due;
        pq_addr.push_back(s_addr);
        pq_due.push_back(due);
      end
    end
    if (pq_addr.size() > 0 && pq_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = pq_addr[0] + 32'd1;
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    if (!s_reset && s_req && !s_gnt && !s_redirect) gnt_wait++;
    else gnt_wait = 0;
    case (mode)
      1:       g = (gnt_wait >= 3);
      2:       g = ($urandom_range(0, 2) != 0);
      default: g = 1'b1;
    endcase
    gnt = g;
    q_reset = p_reset; q_redirect = p_redirect;
    p_reset = s_reset; p_stall = s_stall; p_redirect = s_redirect; p_rpc = s_rpc;
    p_req = s_req; p_gnt = s_gnt; p_addr = s_addr; p_valid = s_valid; p_insn = s_insn; p_pc = s_pc;
  endtask

  initial begin
    int base;
    logic found;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt = 1'b1; rvalid = 1'b0; rdata = '0;
    mode = 0; lat = 1; gnt_wait = 0; last_due = 0;
    exp_pc = RESET_PC; last_pop_pc = '0; exp_stall = '0; exp_redir = '0; pops = 0;
    @(posedge clock);
    #1;
    repeat (3) tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_insn", s_insn, 32'd0);
    chk("rst_pc", s_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall_cnt", d_stall_cnt, 32'd0);
    chk("rst_redir_cnt", d_redir_cnt, 32'd0);
`endif

    // streaming from reset with single-cycle memory
    reset = 1'b0;
    tick(); chk("c0_req", 32'(s_req), 32'd1); chk("c0_addr", s_addr, RESET_PC);
    tick(); chk("c1_valid", 32'(s_valid), 32'd0);
    tick(); chk("c2_valid", 32'(s_valid), 32'd1); chk("c2_insn", s_insn, 32'd1);
    tick(); chk("c3_insn", s_insn, 32'd5);
    stall = 1'b1;
    tick(); chk("c4_insn", s_insn, 32'd9); chk("c4_pc", s_pc, 32'd8); chk("c4_req", 32'(s_req), 32'd0);
    tick(); chk("c5_pc", s_pc, 32'd8); chk("c5_req", 32'(s_req), 32'd0);
    tick(); chk("c6_pc", s_pc, 32'd8); chk("c6_req", 32'(s_req), 32'd0);
    stall = 1'b0;
    tick(); chk("c7_pc", s_pc, 32'd8); chk("c7_req", 32'(s_req), 32'd1); chk("c7_addr", s_addr, 32'd16);
    repeat (4) tick();

    // redirect with two responses in flight
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (pq_addr.size() == 2 && !rvalid) found = 1'b1;
    end
    chk("find_two_outstanding", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0400; gnt = 1'b0;
    tick();
    redirect = 1'b0;
    base = pops;
    for (int i = 0; i < 30 && pops == base; i++) tick();
    chk("redir400_seen", 32'(pops > base), 32'd1);
    chk("redir400_pc", last_pop_pc, 32'h0000_0400);

    // redirect coinciding with rvalid and gnt
    lat = 1;
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0800;
    tick(); chk("same_cycle_req", 32'(s_req), 32'd1);
    redirect = 1'b0;
    tick(); chk("sc_n1_addr", s_addr, 32'h800); chk("sc_n1_valid", 32'(s_valid), 32'd0);
    chk("sc_n1_req", 32'(s_req), 32'd1);
    tick(); chk("sc_n2_valid", 32'(s_valid), 32'd0); chk("sc_n2_addr", s_addr, 32'h804);
    tick(); chk("sc_n3_valid", 32'(s_valid), 32'd1); chk("sc_n3_pc", s_pc, 32'h800);
    chk("sc_n3_insn", s_insn, 32'h801);

    // back-to-back redirects
    redirect = 1'b1; redirect_pc = 32'h0000_0100; tick();
    redirect_pc = 32'h0000_0200; tick();
    redirect = 1'b0;
    base = pops;
    for (int i = 0; i < 30 && pops == base; i++) tick();
    chk("b2b_seen", 32'(pops > base), 32'd1);
    chk("b2b_pc", last_pop_pc, 32'h0000_0200);

    // delayed grant and PC wrap
    mode = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF0; tick();
    redirect = 1'b0;
    base = pops;
    for (int i = 0; i < 100 && pops < base + 6; i++) tick();
    chk("wrap_count", 32'(pops - base), 32'd6);
    chk("wrap_pc", last_pop_pc, 32'h0000_0004);

    // randomized traffic with a mid-run reset
    mode = 2;
    base = pops;
    for (int i = 0; i < 1500; i++) begin
      reset       = (i >= 700 && i < 702);
      stall       = !reset && ($urandom_range(0, 3) == 0);
      redirect    = !reset && ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    repeat (5) tick();
    chk("random_progress", 32'(pops - base > 200), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", d_stall_cnt, exp_stall);
    chk("redir_cnt", d_redir_cnt, exp_redir);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
